// File: rtl/demux_pkg.sv
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared constants and state encoding for the 1-to-4 stream demux.
// Revision : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_1to4_stream_if.sv
// ============================================================================
// Module   : demux_1to4_stream_if
// Brief    : Input stream and four output channels of the 1-to-4 demux.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface demux_1to4_stream_if #(
  parameter int DATA_W = 8
);
  import demux_pkg::*;

  logic [DATA_W-1:0]        in_data;
  logic                     in_last;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_last;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;

  modport master (
    output in_data, in_last, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_last, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/stream_slot.sv
// ============================================================================
// Module   : stream_slot
// Brief    : One-entry registered valid/ready buffer for one output channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  input  logic              d_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] q,
  output logic              q_last
);

  // A load wins over a drain, so a simultaneous drain and load keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      q      <= '0;
      q_last <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q      <= d;
      q_last <= d_last;
    end else if (ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_1to4_stream.sv
// ============================================================================
// Module   : demux_1to4_stream
// Brief    : Packet-aware 1-to-4 valid/ready demux with per-channel buffers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1to4_stream_if.slave   bus,
  output logic                 busy,
  output logic [SEL_W-1:0]     cur_sel
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SEL_W-1:0]         r_cur_sel;
  logic [SEL_W-1:0]         w_sel_nxt;
  logic [SEL_W-1:0]         w_tgt;
  logic                     w_in_ready;
  logic                     w_accept;
  logic [NUM_CH-1:0]        w_load;
  logic [NUM_CH-1:0]        w_valid;
  logic [NUM_CH-1:0]        w_last;
  logic [NUM_CH*DATA_W-1:0] w_data;

  // in_sel only matters at a packet start; mid-packet the locked channel is used.
  assign w_tgt      = (r_state == ST_IDLE) ? bus.in_sel : r_cur_sel;
  assign w_in_ready = !w_valid[w_tgt] || bus.out_ready[w_tgt];
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_load        = '0;
    w_load[w_tgt] = w_accept;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_cur_sel;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_sel_nxt = bus.in_sel;
          if (!bus.in_last) w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_accept && bus.in_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cur_sel <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_sel <= w_sel_nxt;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      stream_slot #(.DATA_W(DATA_W)) u_slot (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load[i]),
        .d      (bus.in_data),
        .d_last (bus.in_last),
        .ready  (bus.out_ready[i]),
        .valid  (w_valid[i]),
        .q      (w_data[i*DATA_W +: DATA_W]),
        .q_last (w_last[i])
      );
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_last  = w_last;
  assign bus.out_data  = w_data;
  assign busy          = (r_state == ST_LOCKED);
  assign cur_sel       = r_cur_sel;

endmodule

`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
// ============================================================================
// Module   : tb_demux_1to4_stream
// Brief    : Table-driven and scoreboard bench for the 1-to-4 stream demux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux_1to4_stream;
  import demux_pkg::*;

  localparam int DATA_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [SEL_W-1:0] cur_sel;

  demux_1to4_stream_if #(.DATA_W(DATA_W)) bus ();

  demux_1to4_stream #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .cur_sel (cur_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
    logic       exp_rdy;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [11];

  int checks   = 0;
  int failures = 0;

  // Scoreboard: one queue of {last, data} per channel, plus the bench's own packet-lock model.
  logic [DATA_W:0] sbq [NUM_CH][$];
  logic            m_locked;
  logic [1:0]      m_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] data,
                       input logic last);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = data;
    bus.in_last  = last;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) sbq[c].delete();
    m_locked = 1'b0;
    m_sel    = 2'd0;
  endtask

  // Called mid-cycle (negedge) when inputs and combinational outputs are settled.
  task automatic sample();
    logic [1:0]      tgt;
    logic            exp_rdy;
    logic [DATA_W:0] e;
    tgt = m_locked ? m_sel : bus.in_sel;
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("out_valid[%0d]", c), 32'(bus.out_valid[c]), 32'(sbq[c].size() != 0));
    exp_rdy = (sbq[tgt].size() == 0) || bus.out_ready[tgt];
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_locked));
    chk("cur_sel", 32'(cur_sel), 32'(m_sel));
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.out_valid[c] && bus.out_ready[c] && sbq[c].size() != 0) begin
        e = sbq[c].pop_front();
        chk($sformatf("out_data[%0d]", c), 32'(bus.out_data[c*DATA_W +: DATA_W]),
            32'(e[DATA_W-1:0]));
        chk($sformatf("out_last[%0d]", c), 32'(bus.out_last[c]), 32'(e[DATA_W]));
      end
    end
    if (bus.in_valid && exp_rdy) begin
      sbq[tgt].push_back({bus.in_last, bus.in_data});
      if (!m_locked) begin
        m_sel    = bus.in_sel;
        m_locked = !bus.in_last;
      end else if (bus.in_last) begin
        m_locked = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 8'h11, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 8'h22, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 8'h33, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'd3, 8'h44, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'd2, 8'hA0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 2'd1, 8'hA1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 2'd1, 8'hA2, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 8'hB0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 2'd3, 8'hB1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0};

    model_reset();
    rst           = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    bus.out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_last", 32'(bus.out_last), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cur_sel", 32'(cur_sel), 32'h0);
    rst = 1'b0;
    step();

    // Single-beat packets, a 3-beat packet with in_sel changing mid-packet, back-to-back start.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].last);
      @(negedge clk);
      sample();
      chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
    end

    // Backpressure on channel 1 while channel 3 keeps flowing.
    bus.out_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'h55, 1'b1);
    step();
    drive(1'b1, 2'd1, 8'h66, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sample();
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_hold_data", 32'(bus.out_data[15:8]), 32'h55);
      @(posedge clk);
      #1;
    end
    drive(1'b1, 2'd3, 8'h77, 1'b1);
    step();
    chk("bp_ch3_valid", 32'(bus.out_valid[3]), 32'h1);
    chk("bp_ch3_data", 32'(bus.out_data[31:24]), 32'h77);
    drive(1'b1, 2'd1, 8'h66, 1'b1);
    step();
    bus.out_ready = 4'hF;
    step();
    chk("bp_new_data", 32'(bus.out_data[15:8]), 32'h66);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    step();

    // Continuous drain and load on channel 0.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'd0, 8'(i), (i == 7));
      step();
      chk("stream_valid", 32'(bus.out_valid[0]), 32'h1);
      chk("stream_data", 32'(bus.out_data[7:0]), 32'(i));
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();

    // Reset mid-packet with channel 3 holding a stalled beat.
    bus.out_ready = 4'b0111;
    drive(1'b1, 2'd3, 8'hC0, 1'b0);
    step();
    drive(1'b1, 2'd0, 8'hC1, 1'b0);
    step();
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_cur_sel", 32'(cur_sel), 32'h0);
    model_reset();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    bus.out_ready = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 2'd1, 8'hD0, 1'b1);
    step();
    chk("post_rst_valid", 32'(bus.out_valid), 32'h2);
    chk("post_rst_data", 32'(bus.out_data[15:8]), 32'hD0);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    step();

    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("drained[%0d]", c), 32'(sbq[c].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
